// File: rtl/icache_nway.sv
`default_nettype none
// ============================================================================
// Module   : icache_nway
// Purpose  : N-way set-associative read-only instruction cache with tree
//            pseudo-LRU replacement, invalid-way-first victim choice,
//            single-cycle flush and a latched miss address.
// Ports    : clk, rst (async, active-high)
//            CPU side : mem_read, mem_address -> mem_rdata, mem_resp, flush
//            L2 side  : pmem_read, pmem_address <- pmem_rdata, pmem_resp
// Revision : 1.0 - initial release
// ============================================================================
module icache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_BYTES = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_read,
    input  logic [31:0]               mem_address,
    output logic [31:0]               mem_rdata,
    output logic                      mem_resp,
    input  logic                      flush,
    output logic                      pmem_read,
    output logic [31:0]               pmem_address,
    input  logic [LINE_BYTES*8-1:0]   pmem_rdata,
    input  logic                      pmem_resp
);

    localparam int c_OFF_W  = $clog2(LINE_BYTES);
    localparam int c_IDX_W  = $clog2(SETS);
    localparam int c_TAG_W  = 32 - c_OFF_W - c_IDX_W;
    localparam int c_WAY_W  = $clog2(WAYS);
    localparam int c_PLRU_W = WAYS - 1;

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_FETCH = 1'b1;

    // Storage: valid/PLRU are flops so reset and flush clear them at once.
    logic [WAYS-1:0]          r_valid [SETS];
    logic [c_PLRU_W-1:0]      r_plru  [SETS];
    logic [c_TAG_W-1:0]       r_tag   [WAYS][SETS];
    logic [LINE_BYTES*8-1:0]  r_data  [WAYS][SETS];

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic [31:0]              r_pmem_addr;
    logic                     r_flush_pend;

    logic [c_IDX_W-1:0]       w_idx;
    logic [c_TAG_W-1:0]       w_tag;
    logic                     w_hit;
    logic [c_WAY_W-1:0]       w_hit_way;
    logic [LINE_BYTES*8-1:0]  w_hit_line;
    logic                     w_flushing;

    logic [c_IDX_W-1:0]       w_fidx;
    logic [c_TAG_W-1:0]       w_ftag;
    logic [WAYS-1:0]          w_fvalid;
    logic [c_PLRU_W-1:0]      w_fplru;
    logic [c_WAY_W-1:0]       w_victim;
    logic                     w_unused;

    assign w_unused   = ^mem_address[1:0];
    assign w_idx      = mem_address[c_OFF_W +: c_IDX_W];
    assign w_tag      = mem_address[31 -: c_TAG_W];
    assign w_flushing = flush | r_flush_pend;

    assign w_fidx     = r_pmem_addr[c_OFF_W +: c_IDX_W];
    assign w_ftag     = r_pmem_addr[31 -: c_TAG_W];
    assign w_fvalid   = r_valid[w_fidx];
    assign w_fplru    = r_plru[w_fidx];
    assign pmem_address = r_pmem_addr;

    // Walk the tree from the root along the accessed way and make every
    // node on the path point at the opposite subtree.
    function automatic logic [c_PLRU_W-1:0] plru_touch(
        input logic [c_PLRU_W-1:0] cur,
        input logic [c_WAY_W-1:0]  way
    );
        logic [c_PLRU_W-1:0] nxt;
        int                  node;
        logic                dir;
        nxt  = cur;
        node = 0;
        for (int l = 0; l < c_WAY_W; l++) begin
            dir = way[c_WAY_W-1-l];
            for (int n = 0; n < c_PLRU_W; n++) begin
                if (n == node) nxt[n] = ~dir;
            end
            node = 2 * node + 1 + int'(dir);
        end
        return nxt;
    endfunction

    // Tag compare; iterating downward lets the lowest hitting way win.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
        end
    end

    assign w_hit_line = r_data[w_hit_way][w_idx];

    // Victim: lowest invalid way, otherwise follow the PLRU tree
    // (node bit 0 means go left).
    always_comb begin
        logic                found;
        logic [c_WAY_W-1:0]  tree_way;
        logic                b;
        int                  node;
        found    = 1'b0;
        w_victim = '0;
        tree_way = '0;
        b        = 1'b0;
        node     = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_fvalid[w] && !found) begin
                found    = 1'b1;
                w_victim = c_WAY_W'(w);
            end
        end
        for (int l = 0; l < c_WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < c_PLRU_W; n++) begin
                if (n == node) b = w_fplru[n];
            end
            tree_way[c_WAY_W-1-l] = b;
            node = 2 * node + 1 + int'(b);
        end
        if (!found) w_victim = tree_way;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (!w_flushing && mem_read && !w_hit) w_state_nxt = c_S_FETCH;
            c_S_FETCH: if (pmem_resp) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_resp  = 1'b0;
        pmem_read = 1'b0;
        mem_rdata = w_hit_line[{mem_address[c_OFF_W-1:2], 5'b0} +: 32];
        case (r_state)
            c_S_IDLE:  mem_resp  = !w_flushing && mem_read && w_hit;
            c_S_FETCH: pmem_read = 1'b1;
            default:   ;
        endcase
    end

    // Valid, PLRU, miss address and deferred flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
            r_pmem_addr  <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_flushing) begin
                        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (mem_read) begin
                        if (w_hit) r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
                        else       r_pmem_addr   <= {mem_address[31:c_OFF_W], {c_OFF_W{1'b0}}};
                    end
                end
                c_S_FETCH: begin
                    // The fill still lands; the flush is replayed in IDLE.
                    if (flush) r_flush_pend <= 1'b1;
                    if (pmem_resp) begin
                        r_valid[w_fidx][w_victim] <= 1'b1;
                        r_plru[w_fidx]            <= plru_touch(w_fplru, w_victim);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset.
    always_ff @(posedge clk) begin
        if (r_state == c_S_FETCH && pmem_resp) begin
            r_tag[w_victim][w_fidx]  <= w_ftag;
            r_data[w_victim][w_fidx] <= pmem_rdata;
        end
    end

endmodule
`default_nettype wire
